// File: rtl/conv_core_clk2.sv
// 2x2 valid-region convolution engine (clk2 domain): buffers one frame of IMG rows
// and IMG kernels, then streams IMG*(IMG-1)^2 results under valid/ready.
module conv_core_clk2 #(
    parameter int PIX_W = 3,
    parameter int IMG   = 6,
    parameter int OUT_W = 8
) (
    input  logic                 clk2,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IMG*PIX_W-1:0] in_row,
    input  logic [4*PIX_W-1:0]   in_kernel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic                 busy
);
    localparam int CW = $clog2(IMG);

    typedef enum logic [1:0] {IDLE, LOAD, CALC} state_t;
    state_t state, state_nxt;

    logic [IMG*PIX_W-1:0] rows [IMG];
    logic [4*PIX_W-1:0]   kers [IMG];
    logic [CW-1:0]        beat_cnt, k_cnt, r_cnt, c_cnt;
    logic [CW-1:0]        k_sel, r_sel, c_sel, r_nx, c_nx;
    logic [4*PIX_W-1:0]   kk;
    logic [PIX_W-1:0]     p00, p01, p10, p11;
    logic [OUT_W-1:0]     result;
    logic                 accept, consume, last_res, load_res;

    assign in_ready = (state != CALC);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;
    assign last_res = (k_cnt == CW'(IMG-1)) && (r_cnt == CW'(IMG-2)) && (c_cnt == CW'(IMG-2));
    assign load_res = (state == CALC) && (!out_valid || out_ready);

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = LOAD;
            LOAD: if (accept && beat_cnt == CW'(IMG-1)) state_nxt = CALC;
            CALC: if (consume && last_res) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Index of the result to register: the current one before the first result of a
    // frame, otherwise the successor, so a new result can be loaded on every consume.
    always_comb begin
        k_sel = k_cnt;
        r_sel = r_cnt;
        c_sel = c_cnt;
        if (out_valid) begin
            if (c_cnt == CW'(IMG-2)) begin
                c_sel = '0;
                if (r_cnt == CW'(IMG-2)) begin
                    r_sel = '0;
                    k_sel = k_cnt + 1'b1;
                end else begin
                    r_sel = r_cnt + 1'b1;
                end
            end else begin
                c_sel = c_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        r_nx   = r_sel + 1'b1;
        c_nx   = c_sel + 1'b1;
        kk     = kers[k_sel];
        p00    = rows[r_sel][c_sel*PIX_W +: PIX_W];
        p01    = rows[r_sel][c_nx*PIX_W +: PIX_W];
        p10    = rows[r_nx][c_sel*PIX_W +: PIX_W];
        p11    = rows[r_nx][c_nx*PIX_W +: PIX_W];
        result = OUT_W'(p00) * OUT_W'(kk[0*PIX_W +: PIX_W])
               + OUT_W'(p01) * OUT_W'(kk[1*PIX_W +: PIX_W])
               + OUT_W'(p10) * OUT_W'(kk[2*PIX_W +: PIX_W])
               + OUT_W'(p11) * OUT_W'(kk[3*PIX_W +: PIX_W]);
    end

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < IMG; i++) begin
                rows[i] <= '0;
                kers[i] <= '0;
            end
            beat_cnt  <= '0;
            k_cnt     <= '0;
            r_cnt     <= '0;
            c_cnt     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (accept) begin
                rows[beat_cnt] <= in_row;
                kers[beat_cnt] <= in_kernel;
                beat_cnt       <= (beat_cnt == CW'(IMG-1)) ? '0 : beat_cnt + 1'b1;
            end
            if (load_res) begin
                if (out_valid && last_res) begin
                    out_valid <= 1'b0;
                    k_cnt     <= '0;
                    r_cnt     <= '0;
                    c_cnt     <= '0;
                end else begin
                    out_valid <= 1'b1;
                    out_data  <= result;
                    k_cnt     <= k_sel;
                    r_cnt     <= r_sel;
                    c_cnt     <= c_sel;
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_core_clk2.sv
// Scoreboard bench for conv_core_clk2: random frames, reference convolution in a queue,
// independent monitor popping on each consumed result.
module tb_conv_core_clk2;
    localparam int PIX_W = 3;
    localparam int IMG   = 6;
    localparam int OUT_W = 8;
    localparam int NRES  = IMG * (IMG-1) * (IMG-1);

    logic                 clk2 = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [IMG*PIX_W-1:0] in_row = '0;
    logic [4*PIX_W-1:0]   in_kernel = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [OUT_W-1:0]     out_data;
    logic                 busy;

    conv_core_clk2 #(.PIX_W(PIX_W), .IMG(IMG), .OUT_W(OUT_W)) dut (
        .clk2(clk2), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row), .in_kernel(in_kernel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk2 = ~clk2;

    int total = 0;
    int bad = 0;
    int exp_q[$];
    int results_seen = 0;
    int ready_mode = 0;
    int ready_phase = 0;
    bit garbage = 0;
    int pix[IMG][IMG];
    int ker[IMG][4];

    task automatic check(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk2) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = (ready_phase == 0);
                ready_phase = (ready_phase + 1) % 3;
            end
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: handshake-level checks and scoreboard pops
    bit stall = 0;
    int held = 0;
    always @(negedge clk2) begin
        if (!rst_n) begin
            stall = 0;
        end else begin
            if (stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, held);
            end
            if (out_valid) check("in_ready_in_calc", in_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_result", out_data, -1);
                else check("result", out_data, exp_q.pop_front());
                results_seen++;
            end
            stall = out_valid && !out_ready;
            held  = out_data;
        end
    end

    task automatic gen_frame(int mode);
        for (int r = 0; r < IMG; r++)
            for (int c = 0; c < IMG; c++)
                case (mode)
                    0: pix[r][c] = 1;
                    1: pix[r][c] = 7;
                    2: pix[r][c] = (r + c) % 8;
                    default: pix[r][c] = $urandom_range(0, 7);
                endcase
        for (int k = 0; k < IMG; k++)
            for (int i = 0; i < 4; i++)
                case (mode)
                    0: ker[k][i] = 1;
                    1: ker[k][i] = 7;
                    2: ker[k][i] = (k < 3) ? ((i == 0) ? 1 : 0) : ((i == 3) ? 1 : 0);
                    default: ker[k][i] = $urandom_range(0, 7);
                endcase
    endtask

    task automatic push_expected();
        for (int k = 0; k < IMG; k++)
            for (int r = 0; r < IMG-1; r++)
                for (int c = 0; c < IMG-1; c++)
                    exp_q.push_back(pix[r][c]*ker[k][0] + pix[r][c+1]*ker[k][1]
                                  + pix[r+1][c]*ker[k][2] + pix[r+1][c+1]*ker[k][3]);
    endtask

    task automatic send_beats(int n, bit gaps);
        logic [IMG*PIX_W-1:0] row;
        logic [4*PIX_W-1:0]   kv;
        for (int b = 0; b < n; b++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    @(posedge clk2); #1;
                end
            end
            for (int c = 0; c < IMG; c++) row[c*PIX_W +: PIX_W] = PIX_W'(pix[b][c]);
            for (int i = 0; i < 4; i++) kv[i*PIX_W +: PIX_W] = PIX_W'(ker[b][i]);
            check("in_ready_load", in_ready, 1);
            in_valid  = 1'b1;
            in_row    = row;
            in_kernel = kv;
            @(posedge clk2); #1;
            if (garbage && b == IMG-1) begin
                in_row    = IMG*PIX_W'($urandom);
                in_kernel = 4*PIX_W'($urandom);
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        exp_q.delete();
        in_valid = 1'b0;
        @(posedge clk2); #3;
        rst_n = 1'b1;
    endtask

    task automatic run_frame(int mode, bit gaps, bit contig);
        int start, n;
        gen_frame(mode);
        push_expected();
        start = results_seen;
        send_beats(IMG, gaps);
        @(negedge clk2);
        check("entry_no_valid", out_valid, 0);
        check("entry_busy", busy, 1);
        check("entry_in_ready", in_ready, 0);
        @(negedge clk2);
        check("first_valid", out_valid, 1);
        n = 1;
        forever begin
            @(negedge clk2);
            if (!out_valid || n >= 4000) break;
            n++;
        end
        if (contig) check("contiguous_valid", n, NRES);
        check("result_count", results_seen - start, NRES);
        check("in_ready_after", in_ready, 1);
        check("idle_busy", busy, 0);
        check("queue_drained", exp_q.size(), 0);
        in_valid = 1'b0;
    endtask

    initial begin
        int cnt, start;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_busy", busy, 0);
        check("reset_in_ready", in_ready, 1);
        repeat (2) @(posedge clk2);
        #3 rst_n = 1'b1;
        @(negedge clk2);

        ready_mode = 0;
        run_frame(0, 0, 1);
        run_frame(1, 0, 1);
        run_frame(2, 1, 1);
        ready_mode = 1;
        run_frame(3, 1, 0);
        ready_mode = 0;
        garbage = 1;
        run_frame(3, 0, 1);
        run_frame(0, 0, 1);
        garbage = 0;

        gen_frame(3);
        push_expected();
        start = results_seen;
        send_beats(IMG, 0);
        cnt = 0;
        while (results_seen - start < 40 && cnt < 1000) begin
            @(negedge clk2);
            cnt++;
        end
        check("reached_result_40", (results_seen - start >= 40) ? 1 : 0, 1);
        #1;
        pulse_reset();
        run_frame(3, 0, 1);

        gen_frame(3);
        send_beats(3, 1);
        check("partial_busy", busy, 1);
        pulse_reset();
        @(negedge clk2);
        run_frame(3, 1, 1);

        ready_mode = 2;
        run_frame(3, 1, 0);
        run_frame(2, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
